// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock controller.
//   - cpu_state_t : controller FSM states
//   - MODE_*      : encodings of the 2-bit Mode_i input (2'b11 behaves as HALT)
//   - DEF_*       : default parameter values for cpu_clk_ctrl
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        IDLE     = 2'd1,
        RUN      = 2'd2,
        STEP     = 2'd3
    } cpu_state_t;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_DIV_W      = 8;
    localparam int DEF_RST_CYCLES = 16;
    localparam int DEF_CNT_W      = 32;

endpackage

// File: rtl/clk_div_tick.sv
// Base-tick divider for cpu_clk_ctrl.
// Counts 0..Div-1 while enabled and flags a tick in the cycle it wraps.
// A pending ratio (written by i_cfg_load) only becomes the active ratio at a
// CPU-cycle boundary (phase 0 with the count at 0), so every tick within one
// CPU cycle uses the same spacing.
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_en            : divider counts (controller is in RUN or STEP)
//   i_clr           : hold the count at 0 (controller not running)
//   i_phase0        : phase counter is at 0
//   i_cfg_load      : capture i_div into the pending register
//   i_div           : requested ratio, 0 is treated as 1
//   o_tick          : base tick, combinational, valid only while i_en
module clk_div_tick #(
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_phase0,
    input  logic             i_cfg_load,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_pend;
    logic [DIV_W-1:0] r_active;
    logic [DIV_W-1:0] w_div_in;
    logic [DIV_W-1:0] w_div_eff;
    logic             w_boundary;

    assign w_div_in   = (i_div == '0) ? DIV_W'(1) : i_div;
    assign w_boundary = i_phase0 && (r_cnt == '0);

    // At the boundary the ratio for the upcoming CPU cycle is chosen here and
    // used immediately, with a same-cycle load taking priority over pending.
    assign w_div_eff = !w_boundary ? r_active :
                       i_cfg_load  ? w_div_in : r_pend;

    assign o_tick = i_en && (r_cnt == (w_div_eff - DIV_W'(1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_pend   <= DIV_W'(1);
            r_active <= DIV_W'(1);
        end else begin
            if (i_cfg_load) begin
                r_pend <= w_div_in;
            end
            if (w_boundary) begin
                r_active <= w_div_eff;
            end
            if (i_clr || o_tick) begin
                r_cnt <= '0;
            end else if (i_en) begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock controller: releases the CPU reset after a hold period, then
// produces NUM_CH one-hot phase enables per CPU cycle, either continuously
// (RUN) or one cycle per step request (STEP). Cycles are never cut short
// except by Reset_n.
// Optional feature: define CPU_CLK_CTRL_CYCLE_CNT_EN to add Cycle_cnt_o, a
// wrapping count of completed CPU cycles.
// Ports:
//   Clock        : clock, rising edge
//   Reset_n      : asynchronous active-low reset
//   Div_i        : base-tick divide ratio (0 acts as 1)
//   Cfg_load     : strobe capturing Div_i (applied at next CPU-cycle boundary)
//   Mode_i       : 00 HALT, 01 RUN, 10 STEP, 11 HALT
//   Step_i       : single-cycle request, honoured only in IDLE with Mode STEP
//   Cpu_rst_n_o  : registered active-low CPU reset
//   Ce_o         : registered one-hot phase enables
//   Busy_o       : CPU cycle in progress (through the final phase pulse)
//   Cycle_cnt_o  : completed CPU cycles (only with CPU_CLK_CTRL_CYCLE_CNT_EN)
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DIV_W      = DEF_DIV_W,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [DIV_W-1:0]  Div_i,
    input  logic              Cfg_load,
    input  logic [1:0]        Mode_i,
    input  logic              Step_i,
    output logic              Cpu_rst_n_o,
    output logic [NUM_CH-1:0] Ce_o,
    output logic              Busy_o
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0]  Cycle_cnt_o
`endif
);

    localparam int         PH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [7:0] HOLD_END = 8'(RST_CYCLES);

    if (NUM_CH < 1 || NUM_CH > 8 || DIV_W < 1 ||
        RST_CYCLES < 1 || RST_CYCLES > 255 || CNT_W < 1) begin : g_param_chk
        $error("cpu_clk_ctrl: parameter out of legal range");
    end

    cpu_state_t        r_state;
    cpu_state_t        w_state_nxt;
    logic [7:0]        r_hold;
    logic              r_cpu_rst_n;
    logic [NUM_CH-1:0] r_ce;
    logic [NUM_CH-1:0] w_ce_nxt;
    logic              r_busy;
    logic [PH_W-1:0]   r_phase;
    logic              w_running;
    logic              w_tick;
    logic              w_last;

    assign w_running = (r_state == RUN) || (r_state == STEP);
    assign w_last    = w_tick && (r_phase == PH_W'(NUM_CH - 1));

    clk_div_tick #(
        .DIV_W (DIV_W)
    ) u_div (
        .i_clk      (Clock),
        .i_rst_n    (Reset_n),
        .i_en       (w_running),
        .i_clr      (!w_running),
        .i_phase0   (r_phase == '0),
        .i_cfg_load (Cfg_load),
        .i_div      (Div_i),
        .o_tick     (w_tick)
    );

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ce
        assign w_ce_nxt[k] = w_tick && (r_phase == PH_W'(k));
    end

    // RUN and STEP only leave on the final phase tick, so cycles always
    // complete; a mode change in RUN waits for that tick.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RST_HOLD: if (r_hold == HOLD_END) w_state_nxt = IDLE;
            IDLE: begin
                if (Mode_i == MODE_RUN) begin
                    w_state_nxt = RUN;
                end else if (Mode_i == MODE_STEP && Step_i) begin
                    w_state_nxt = STEP;
                end
            end
            RUN:      if (w_last && Mode_i != MODE_RUN) w_state_nxt = IDLE;
            STEP:     if (w_last) w_state_nxt = IDLE;
            default:  w_state_nxt = RST_HOLD;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= RST_HOLD;
            r_hold      <= '0;
            r_cpu_rst_n <= 1'b0;
            r_ce        <= '0;
            r_busy      <= 1'b0;
            r_phase     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cpu_rst_n <= (w_state_nxt != RST_HOLD);
            r_ce        <= w_ce_nxt;
            // Stays high for the cycle showing the last phase pulse.
            r_busy      <= (w_state_nxt == RUN) || (w_state_nxt == STEP) || w_last;
            if (r_state == RST_HOLD && r_hold != HOLD_END) begin
                r_hold <= r_hold + 8'd1;
            end
            if (!w_running) begin
                r_phase <= '0;
            end else if (w_tick) begin
                r_phase <= w_last ? '0 : r_phase + PH_W'(1);
            end
        end
    end

    assign Cpu_rst_n_o = r_cpu_rst_n;
    assign Ce_o        = r_ce;
    assign Busy_o      = r_busy;

`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
    logic [CNT_W-1:0] r_cyc_cnt;

    // Steps on the same edge that raises the final phase enable.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cyc_cnt <= '0;
        end else if (w_last) begin
            r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
        end
    end

    assign Cycle_cnt_o = r_cyc_cnt;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl (NUM_CH=4, DIV_W=8, RST_CYCLES=16).
// The reference model tracks position within a CPU cycle as an elapsed cycle
// count and derives phase pulses arithmetically from the active ratio.
module tb_cpu_clk_ctrl;

    localparam int NUM_CH     = 4;
    localparam int DIV_W      = 8;
    localparam int RST_CYCLES = 16;
    localparam int CNT_W      = 32;

    logic              Clock    = 1'b0;
    logic              Reset_n  = 1'b0;
    logic [DIV_W-1:0]  Div_i    = '0;
    logic              Cfg_load = 1'b0;
    logic [1:0]        Mode_i   = 2'b00;
    logic              Step_i   = 1'b0;
    logic              Cpu_rst_n_o;
    logic [NUM_CH-1:0] Ce_o;
    logic              Busy_o;
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
    logic [CNT_W-1:0]  Cycle_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;

    // reference model state: 0 = reset hold, 1 = idle, 2 = executing a CPU cycle
    int                m_st;
    bit                m_step;
    int                m_rel;
    int                m_div;
    int                m_pend;
    int                m_hold;
    logic [NUM_CH-1:0] e_ce;
    logic              e_busy;
    logic              e_rst;
    logic [CNT_W-1:0]  e_cnt;

    always #5 Clock = ~Clock;

    cpu_clk_ctrl #(
        .NUM_CH     (NUM_CH),
        .DIV_W      (DIV_W),
        .RST_CYCLES (RST_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .Div_i       (Div_i),
        .Cfg_load    (Cfg_load),
        .Mode_i      (Mode_i),
        .Step_i      (Step_i),
        .Cpu_rst_n_o (Cpu_rst_n_o),
        .Ce_o        (Ce_o),
        .Busy_o      (Busy_o)
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
        ,
        .Cycle_cnt_o (Cycle_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_st   = 0;
        m_hold = 0;
        m_pend = 1;
        m_div  = 1;
        m_rel  = 0;
        m_step = 0;
        e_ce   = '0;
        e_busy = 1'b0;
        e_rst  = 1'b0;
        e_cnt  = '0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic m_edge();
        int nd;
        int ph;
        nd   = (Div_i == '0) ? 1 : int'(Div_i);
        e_ce = '0;
        case (m_st)
            0: begin
                e_busy = 1'b0;
                m_hold++;
                if (m_hold == RST_CYCLES + 1) begin
                    m_st  = 1;
                    e_rst = 1'b1;
                end
            end
            1: begin
                e_busy = 1'b0;
                if (Mode_i == 2'b01) begin
                    m_st = 2; m_step = 0; m_rel = 0; e_busy = 1'b1;
                end else if (Mode_i == 2'b10 && Step_i) begin
                    m_st = 2; m_step = 1; m_rel = 0; e_busy = 1'b1;
                end
            end
            default: begin
                e_busy = 1'b1;
                if (m_rel == 0) m_div = Cfg_load ? nd : m_pend;
                if ((m_rel + 1) % m_div == 0) begin
                    ph = (m_rel + 1) / m_div - 1;
                    e_ce[ph] = 1'b1;
                    if (ph == NUM_CH - 1) begin
                        e_cnt = e_cnt + 1'b1;
                        m_rel = 0;
                        if (m_step || Mode_i != 2'b01) m_st = 1;
                    end else begin
                        m_rel++;
                    end
                end else begin
                    m_rel++;
                end
            end
        endcase
        if (Cfg_load) m_pend = nd;
    endtask

    task automatic cyc();
        @(posedge Clock);
        m_edge();
        #1;
        if (Ce_o != '0) pulses++;
        chk("ce", 64'(Ce_o), 64'(e_ce));
        chk("busy", 64'(Busy_o), 64'(e_busy));
        chk("cpu_rst", 64'(Cpu_rst_n_o), 64'(e_rst));
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
        chk("cyc_cnt", 64'(Cycle_cnt_o), 64'(e_cnt));
`endif
    endtask

    task automatic wait_ce(input logic [NUM_CH-1:0] v, input string tag);
        int i;
        i = 0;
        while (Ce_o !== v && i < 200) begin
            cyc();
            i++;
        end
        chk(tag, 64'(Ce_o), 64'(v));
    endtask

    initial begin
        m_reset();
        #1;
        chk("rst_ce", 64'(Ce_o), 64'(0));
        chk("rst_busy", 64'(Busy_o), 64'(0));
        chk("rst_cpu", 64'(Cpu_rst_n_o), 64'(0));
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
        chk("rst_cnt", 64'(Cycle_cnt_o), 64'(0));
`endif
        #16 Reset_n = 1'b1;

        // reset hold: low through edge RST_CYCLES, high from edge RST_CYCLES+1
        for (int i = 1; i <= RST_CYCLES + 3; i++) begin
            cyc();
            chk("hold_rel", 64'(Cpu_rst_n_o), 64'(i > RST_CYCLES));
        end

        // RUN with ratio 1
        Mode_i = 2'b01;
        repeat (14) cyc();

        // load ratio 3 mid-cycle
        wait_ce(4'b0010, "sync_div");
        Div_i = 8'd3; Cfg_load = 1'b1;
        cyc();
        Cfg_load = 1'b0;
        repeat (30) cyc();

        // RUN -> HALT while phase 1 is showing
        wait_ce(4'b0010, "sync_halt");
        Mode_i = 2'b00;
        repeat (16) cyc();
        chk("halt_busy", 64'(Busy_o), 64'(0));

        // STEP with ratio 2 and a second request while busy
        Div_i = 8'd2; Cfg_load = 1'b1; Mode_i = 2'b10;
        cyc();
        Cfg_load = 1'b0;
        pulses = 0;
        Step_i = 1'b1; cyc(); Step_i = 1'b0;
        repeat (3) cyc();
        Step_i = 1'b1; cyc(); Step_i = 1'b0;
        repeat (14) cyc();
        chk("step_pulses", 64'(pulses), 64'(NUM_CH));

        // randomized modes, steps, ratio loads (including ratio 0)
        repeat (700) begin
            Mode_i   = 2'($urandom_range(0, 3));
            Step_i   = ($urandom_range(0, 3) == 0);
            Cfg_load = ($urandom_range(0, 9) == 0);
            Div_i    = 8'($urandom_range(0, 4));
            cyc();
        end
        Cfg_load = 1'b0; Step_i = 1'b0;

        // reset in the middle of a cycle
        Div_i = 8'd1; Cfg_load = 1'b1; Mode_i = 2'b01;
        cyc();
        Cfg_load = 1'b0;
        wait_ce(4'b0100, "sync_rst");
        #2 Reset_n = 1'b0;
        m_reset();
        #1;
        chk("mid_rst_ce", 64'(Ce_o), 64'(0));
        chk("mid_rst_cpu", 64'(Cpu_rst_n_o), 64'(0));
        chk("mid_rst_busy", 64'(Busy_o), 64'(0));
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
        chk("mid_rst_cnt", 64'(Cycle_cnt_o), 64'(0));
`endif
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_held_ce", 64'(Ce_o), 64'(0));
        Reset_n = 1'b1;
        repeat (RST_CYCLES + 12) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
